alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 175 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Handshake rules: a request transfers when req_valid[i] and req_ready[i]
// are both high at a rising edge; a response transfers when rsp_valid and
// rsp_ready are both high at a rising edge. Every transfer uses this rule.
// The FSM walks IDLE -> EXEC -> RESP -> IDLE. It takes one operation at a
// time, so the best rate is one operation every three cycles.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req0_cmd,
  input  logic [3:0]   req1_cmd,
  output logic [W-1:0] alu_val1,
  output logic [W-1:0] alu_val2,
  output logic [3:0]   alu_cmd,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic [15:0]  op_count,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] MAX_CMD = 4'd9;

  state_e       state_q, state_d;
  logic         last_q, last_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic [3:0]   op_cmd_q, op_cmd_d;
  logic         op_id_q, op_id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_zero_q, rsp_zero_d;
  logic         rsp_err_q, rsp_err_d;
  logic [15:0]  op_count_q, op_count_d;

  logic grant_id;
  logic accept;
  logic cmd_illegal;

  // Round-robin grant: if both requesters are valid, the one not served last wins.
  // req_ready is held low while reset is high, so no request can transfer in a reset cycle.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_q;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
    req_ready = 2'b00;
    if ((state_q == IDLE) && !reset && (req_valid != 2'b00)) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
    accept = |(req_valid & req_ready);
  end

  // The shared ALU sees the latched operation only during EXEC; at all other times it sees zeros.
  always_comb begin
    alu_val1 = '0;
    alu_val2 = '0;
    alu_cmd  = 4'd0;
    if (state_q == EXEC) begin
      alu_val1 = op_a_q;
      alu_val2 = op_b_q;
      alu_cmd  = op_cmd_q;
    end
  end

  // Next-state and next-register values for the whole datapath.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cmd_d    = op_cmd_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    cmd_illegal = (op_cmd_q > MAX_CMD);
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d   = grant_id ? req1_a   : req0_a;
          op_b_d   = grant_id ? req1_b   : req0_b;
          op_cmd_d = grant_id ? req1_cmd : req0_cmd;
          op_id_d  = grant_id;
          last_d   = grant_id;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // An illegal op code still spends its EXEC cycle, but the ALU result is discarded.
        rsp_err_d   = cmd_illegal;
        rsp_data_d  = cmd_illegal ? '0 : alu_out;
        rsp_zero_d  = cmd_illegal ? 1'b0 : alu_zero;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset. Reset drops any pending response without counting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cmd_q    <= 4'd0;
      op_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cmd_q    <= op_cmd_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. It contains a reference ALU, a response
// scoreboard queue and a grant log.
// Inputs are driven 1 ns after each rising edge. Outputs are sampled on the falling edge.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int SW = $clog2(W);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_cmd, req1_cmd;
  logic [W-1:0] alu_val1, alu_val2;
  logic [3:0]   alu_cmd;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic         rsp_err;
  logic [15:0]  op_count;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [W+2:0] exp_q[$];
  int           grant_log[$];

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // Clock generation and overall time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference ALU. It drives the DUT and also produces the expected results.
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] cmd);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (cmd)
      4'd0:       alu_ref = a + b;
      4'd1:       alu_ref = a - b;
      4'd2:       alu_ref = a & b;
      4'd3:       alu_ref = a | b;
      4'd4:       alu_ref = ~(a | b);
      4'd5:       alu_ref = a ^ b;
      4'd6, 4'd7: alu_ref = a << sh;
      4'd8:       alu_ref = $signed(a) >>> sh;
      4'd9:       alu_ref = a >> sh;
      default:    alu_ref = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out  = alu_ref(alu_val1, alu_val2, alu_cmd);
  assign alu_zero = (alu_out == '0);

  // Expected response packed as {id, err, zero, data}.
  function automatic logic [W+2:0] exp_resp(input logic id, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [3:0] cmd);
    logic         err;
    logic [W-1:0] d;
    err = (cmd > 4'd9);
    d   = err ? '0 : alu_ref(a, b, cmd);
    exp_resp = {id, err, (!err && d == '0), d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: push on each request transfer, pop and compare on each response transfer.
  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid[0] && req_ready[0]) begin
        exp_q.push_back(exp_resp(1'b0, req0_a, req0_b, req0_cmd));
        grant_log.push_back(0);
      end
      if (req_valid[1] && req_ready[1]) begin
        exp_q.push_back(exp_resp(1'b1, req1_a, req1_b, req1_cmd));
        grant_log.push_back(1);
      end
      if (rsp_valid && rsp_ready) begin
        check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          check("sb_rsp", 64'({rsp_id, rsp_err, rsp_zero, rsp_data}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    sample();
    while (exp_q.size() != 0 && n < 40) begin
      sample();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
  endtask

  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] cmd);
    if (id) begin
      req1_a = a; req1_b = b; req1_cmd = cmd; req_valid = 2'b10;
    end else begin
      req0_a = a; req0_b = b; req0_cmd = cmd; req_valid = 2'b01;
    end
    rsp_ready = 1'b1;
    sample();
    step();
    req_valid = 2'b00;
    drain();
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_cmd = 4'd0; req1_cmd = 4'd0;
    step(); step();
    // Reset state
    sample();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_alu_cmd", 64'(alu_cmd), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    step();
    reset = 1'b0; req_valid = 2'b00; exp_q.delete();

    // Single ADD from requester 0 with cycle-by-cycle timing
    req0_a = 32'd5; req0_b = 32'd7; req0_cmd = 4'd0; req_valid = 2'b01; rsp_ready = 1'b0;
    sample();
    check("t1_req_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00; req0_a = 32'd99;
    sample();
    check("t1_state_exec", 64'(dbg_state), 64'(S_EXEC));
    check("t1_alu_cmd", 64'(alu_cmd), 64'd0);
    check("t1_alu_val1", 64'(alu_val1), 64'd5);
    check("t1_alu_val2", 64'(alu_val2), 64'd7);
    check("t1_ready_exec", 64'(req_ready), 64'd0);
    step();
    sample();
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_rsp_id", 64'(rsp_id), 64'd0);
    check("t1_rsp_data", 64'(rsp_data), 64'd12);
    check("t1_rsp_zero", 64'(rsp_zero), 64'd0);
    check("t1_alu_idle", 64'(alu_val1), 64'd0);
    step();
    rsp_ready = 1'b1;
    drain();
    sample();
    check("t1_op_count", 64'(op_count), 64'd1);
    step();

    // Round-robin under continuous contention
    do_reset();
    grant_log.delete();
    rsp_ready = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 60) begin
      req0_a = $urandom; req0_b = $urandom; req0_cmd = 4'($urandom_range(0, 9));
      req1_a = $urandom; req1_b = $urandom; req1_cmd = 4'($urandom_range(0, 9));
      req_valid = 2'b11;
      sample();
      step();
      n++;
    end
    req_valid = 2'b00;
    check("t2_grant_count", 64'(grant_log.size()), 64'd4);
    drain();
    sample();
    check("t2_op_count", 64'(op_count), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
    end
    step();

    // SUB to zero from requester 1
    req1_a = 32'd9; req1_b = 32'd9; req1_cmd = 4'd1; req_valid = 2'b10; rsp_ready = 1'b0;
    sample();
    step();
    req_valid = 2'b00;
    sample();
    step();
    sample();
    check("t3_rsp_zero", 64'(rsp_zero), 64'd1);
    check("t3_rsp_data", 64'(rsp_data), 64'd0);
    check("t3_rsp_id", 64'(rsp_id), 64'd1);
    step();
    rsp_ready = 1'b1;
    drain();

    // Illegal op code from requester 0
    do_op(1'b0, 32'h1234, 32'h0001, 4'd12);
    sample();
    check("t4_rsp_err", 64'(rsp_err), 64'd1);
    check("t4_rsp_data", 64'(rsp_data), 64'd0);
    check("t4_op_count", 64'(op_count), 64'd6);
    step();

    // Back-pressure in RESP while both requesters stay valid
    req0_a = 32'd1; req0_b = 32'd2; req0_cmd = 4'd0;
    req1_a = 32'd3; req1_b = 32'd5; req1_cmd = 4'd5;
    req_valid = 2'b11; rsp_ready = 1'b0;
    sample();
    check("t5_first_grant", 64'(req_ready), 64'd2);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      sample();
      check($sformatf("t5_hold_valid%0d", k), 64'(rsp_valid), 64'd1);
      check($sformatf("t5_hold_data%0d", k), 64'({rsp_id, rsp_err, rsp_zero, rsp_data}),
            64'({1'b1, 1'b0, 1'b0, 32'd6}));
      check($sformatf("t5_hold_ready%0d", k), 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    sample();
    check("t5_ready_at_hs", 64'(req_ready), 64'd0);
    step();
    sample();
    check("t5_ready_after_hs", 64'(req_ready), 64'd1);
    step();
    req_valid = 2'b00;
    drain();

    // Reset during EXEC
    do_reset();
    req0_a = 32'hF0; req0_b = 32'h3C; req0_cmd = 4'd2; req_valid = 2'b01; rsp_ready = 1'b1;
    sample();
    step();
    req_valid = 2'b00;
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    sample();
    check("t6_exec_rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("t6_exec_rst_valid", 64'(rsp_valid), 64'd0);
    check("t6_exec_rst_count", 64'(op_count), 64'd0);
    check("t6_exec_rst_alu", 64'(alu_val1), 64'd0);
    step();

    // Reset during RESP
    req1_a = 32'h5; req1_b = 32'hA; req1_cmd = 4'd3; req_valid = 2'b10; rsp_ready = 1'b0;
    sample();
    step();
    req_valid = 2'b00;
    step();
    sample();
    check("t7_in_resp", 64'(rsp_valid), 64'd1);
    step();
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    sample();
    check("t7_resp_rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("t7_resp_rst_valid", 64'(rsp_valid), 64'd0);
    check("t7_resp_rst_count", 64'(op_count), 64'd0);
    check("t7_resp_rst_data", 64'(rsp_data), 64'd0);
    step();

    // op_count wrap: preload 0xFFFF, then one more operation
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    sample();
    check("t8_preset", 64'(op_count), 64'hFFFF);
    step();
    do_op(1'b1, 32'h8000_0000, 32'd4, 4'd8);
    sample();
    check("t8_wrap", 64'(op_count), 64'd0);
    step();

    check("sb_final_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
